// File: rtl/branch_queue_pkg.sv
// Shared constants for the branch queue that feeds the 8-thread barrel PC stage.
package branch_queue_pkg;
  localparam int NTHREADS = 8;
  localparam int BQ_DEPTH = 8;
  localparam int BQ_TID_W = $clog2(NTHREADS);
  localparam int BQ_XLEN  = 32;
endpackage

// File: rtl/branch_queue_match_oldest.sv
// Combinational age-ordered finder: index of the oldest occupied, unresolved entry
// belonging to query_tid, searching forward from the read pointer.
module bq_match_oldest #(
  parameter int DEPTH = 8,
  parameter int TID_W = 3,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       occ,
  input  logic [DEPTH-1:0]       resolved,
  input  logic [DEPTH*TID_W-1:0] tid_flat,
  input  logic [PTR_W-1:0]       rd_ptr,
  input  logic [TID_W-1:0]       query_tid,
  output logic                   hit,
  output logic [PTR_W-1:0]       idx
);
  logic [PTR_W-1:0] slot;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      slot = rd_ptr + PTR_W'(k);
      if (!hit && occ[slot] && !resolved[slot] &&
          tid_flat[int'(slot)*TID_W +: TID_W] == query_tid) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end
endmodule

// File: rtl/branch_queue.sv
// In-order queue of outstanding branches; the head entry drives the PC stage branch inputs.
// Handshake: an entry retires when the head is resolved and either not taken, or br_ack_i && !pc_stall_i.
module branch_queue
  import branch_queue_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH,
  parameter int TID_W = BQ_TID_W,
  parameter int XLEN  = BQ_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  input  logic [TID_W-1:0]         enq_thread_id_i,
  output logic                     full_o,
  input  logic                     res_valid_i,
  input  logic [TID_W-1:0]         res_thread_id_i,
  input  logic                     res_taken_i,
  input  logic [XLEN-1:0]          res_target_i,
  input  logic                     pc_stall_i,
  input  logic                     br_ack_i,
  output logic                     branch_fifo_empty_o,
  output logic [TID_W-1:0]         br_thread_id_o,
  output logic                     br_valid_o,
  output logic                     br_true_o,
  output logic [XLEN-1:0]          br_pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic             resolved;
    logic             taken;
    logic [XLEN-1:0]  target;
  } br_entry_t;

  br_entry_t              entries [DEPTH];
  logic [DEPTH-1:0]       occ;
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   err;

  logic [DEPTH-1:0]       res_vec;
  logic [DEPTH*TID_W-1:0] tid_flat;
  logic                   hit;
  logic [PTR_W-1:0]       hit_idx;
  br_entry_t              head;
  logic                   empty, full, pop, push_ok;

  always_comb begin
    res_vec  = '0;
    tid_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      res_vec[i]                  = entries[i].resolved;
      tid_flat[i*TID_W +: TID_W]  = entries[i].tid;
    end
  end

  bq_match_oldest #(.DEPTH(DEPTH), .TID_W(TID_W), .PTR_W(PTR_W)) u_match (
    .occ       (occ),
    .resolved  (res_vec),
    .tid_flat  (tid_flat),
    .rd_ptr    (rd_ptr),
    .query_tid (res_thread_id_i),
    .hit       (hit),
    .idx       (hit_idx)
  );

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = entries[rd_ptr];
  assign pop     = !empty && head.resolved && (!head.taken || (br_ack_i && !pc_stall_i));
  assign push_ok = enq_valid_i && (!full || pop);

  assign branch_fifo_empty_o = empty;
  assign full_o              = full;
  assign count_o             = count;
  assign err_o               = err;
  assign br_thread_id_o      = empty ? '0 : head.tid;
  assign br_valid_o          = !empty && head.resolved;
  assign br_true_o           = br_valid_o && head.taken;
  assign br_pc_o             = br_true_o ? head.target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      // A matched entry is never the popping head (pop needs resolved=1).
      if (res_valid_i && hit) begin
        entries[hit_idx].resolved <= 1'b1;
        entries[hit_idx].taken    <= res_taken_i;
        entries[hit_idx].target   <= res_target_i;
      end
      if (pop) begin
        entries[rd_ptr] <= '0;
        occ[rd_ptr]     <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      // Full+pop: wr_ptr == rd_ptr, so the push below overrides the pop's clear.
      if (push_ok) begin
        entries[wr_ptr] <= '{tid: enq_thread_id_i, resolved: 1'b0, taken: 1'b0, target: '0};
        occ[wr_ptr]     <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((res_valid_i && !hit) || (enq_valid_i && full && !pop)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_queue.sv
// Self-checking bench for branch_queue: directed scenarios plus random traffic vs a queue model.
module tb_branch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid_i = 1'b0;
  logic [2:0]  enq_thread_id_i = '0;
  logic        full_o;
  logic        res_valid_i = 1'b0;
  logic [2:0]  res_thread_id_i = '0;
  logic        res_taken_i = 1'b0;
  logic [31:0] res_target_i = '0;
  logic        pc_stall_i = 1'b0;
  logic        br_ack_i = 1'b0;
  logic        branch_fifo_empty_o;
  logic [2:0]  br_thread_id_o;
  logic        br_valid_o, br_true_o;
  logic [31:0] br_pc_o;
  logic [3:0]  count_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_queue dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid_i), .enq_thread_id_i(enq_thread_id_i), .full_o(full_o),
    .res_valid_i(res_valid_i), .res_thread_id_i(res_thread_id_i),
    .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .pc_stall_i(pc_stall_i), .br_ack_i(br_ack_i),
    .branch_fifo_empty_o(branch_fifo_empty_o), .br_thread_id_o(br_thread_id_o),
    .br_valid_o(br_valid_o), .br_true_o(br_true_o), .br_pc_o(br_pc_o),
    .count_o(count_o), .err_o(err_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: a plain FIFO of outstanding branches, oldest at index 0.
  typedef struct {
    logic [2:0]  tid;
    bit          res;
    bit          tk;
    logic [31:0] tgt;
  } m_entry_t;
  m_entry_t exp_q[$];
  bit       m_err = 0;

  task automatic model_step();
    bit pop, hit, push;
    int hi;
    m_entry_t e;
    if (rst) begin
      exp_q.delete();
      m_err = 0;
      return;
    end
    pop = exp_q.size() > 0 && exp_q[0].res && (!exp_q[0].tk || (br_ack_i && !pc_stall_i));
    hit = 0;
    hi  = 0;
    if (res_valid_i) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (!hit && !exp_q[i].res && exp_q[i].tid == res_thread_id_i) begin
          hit = 1;
          hi  = i;
        end
      if (hit) begin
        exp_q[hi].res = 1;
        exp_q[hi].tk  = res_taken_i;
        exp_q[hi].tgt = res_target_i;
      end else m_err = 1;
    end
    push = enq_valid_i && (exp_q.size() < 8 || pop);
    if (enq_valid_i && !push) m_err = 1;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      e.tid = enq_thread_id_i; e.res = 0; e.tk = 0; e.tgt = '0;
      exp_q.push_back(e);
    end
  endtask

  // Driver: inputs are set before calling tick; sampling happens 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    enq_valid_i = 0; res_valid_i = 0; res_taken_i = 0; br_ack_i = 0; pc_stall_i = 0;
  endtask

  task automatic push(input logic [2:0] tid);
    enq_valid_i = 1; enq_thread_id_i = tid; tick();
  endtask

  task automatic resolve(input logic [2:0] tid, input bit tk, input logic [31:0] tgt);
    res_valid_i = 1; res_thread_id_i = tid; res_taken_i = tk; res_target_i = tgt; tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (branch_fifo_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b exp 1", branch_fifo_empty_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_checks++; if (full_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_full_err got %0b%0b exp 00", full_o, err_o); end
    n_checks++; if ({br_valid_o, br_true_o, br_thread_id_o, br_pc_o} !== '0) begin n_fail++; $display("FAIL reset_head got %0b %0b %0d %0h exp zeros", br_valid_o, br_true_o, br_thread_id_o, br_pc_o); end
  endtask

  task automatic test_taken_redirect();
    push(3'd3);
    n_checks++; if (branch_fifo_empty_o !== 1'b0 || br_thread_id_o !== 3'd3 || br_valid_o !== 1'b0 || count_o !== 4'd1) begin n_fail++; $display("FAIL push_head got e=%0b t=%0d v=%0b c=%0d exp e=0 t=3 v=0 c=1", branch_fifo_empty_o, br_thread_id_o, br_valid_o, count_o); end
    resolve(3'd3, 1, 32'h100);
    n_checks++; if (br_valid_o !== 1'b1 || br_true_o !== 1'b1 || br_pc_o !== 32'h100) begin n_fail++; $display("FAIL taken_head got v=%0b t=%0b pc=%0h exp 1 1 100", br_valid_o, br_true_o, br_pc_o); end
    br_ack_i = 1; pc_stall_i = 1; tick();
    n_checks++; if (count_o !== 4'd1 || br_pc_o !== 32'h100) begin n_fail++; $display("FAIL stalled_ack got c=%0d pc=%0h exp 1 100", count_o, br_pc_o); end
    br_ack_i = 1; pc_stall_i = 0; tick();
    n_checks++; if (branch_fifo_empty_o !== 1'b1 || count_o !== 4'd0 || br_valid_o !== 1'b0) begin n_fail++; $display("FAIL ack_retire got e=%0b c=%0d v=%0b exp 1 0 0", branch_fifo_empty_o, count_o, br_valid_o); end
  endtask

  task automatic test_not_taken_order();
    push(3'd1); push(3'd2);
    resolve(3'd2, 0, 32'h0);
    n_checks++; if (br_thread_id_o !== 3'd1 || br_valid_o !== 1'b0 || count_o !== 4'd2) begin n_fail++; $display("FAIL nt_younger got t=%0d v=%0b c=%0d exp 1 0 2", br_thread_id_o, br_valid_o, count_o); end
    resolve(3'd1, 0, 32'h0);
    n_checks++; if (br_thread_id_o !== 3'd1 || br_valid_o !== 1'b1 || br_true_o !== 1'b0 || count_o !== 4'd2) begin n_fail++; $display("FAIL nt_head got t=%0d v=%0b tr=%0b c=%0d exp 1 1 0 2", br_thread_id_o, br_valid_o, br_true_o, count_o); end
    tick();
    n_checks++; if (br_thread_id_o !== 3'd2 || br_valid_o !== 1'b1 || count_o !== 4'd1) begin n_fail++; $display("FAIL nt_retire1 got t=%0d v=%0b c=%0d exp 2 1 1", br_thread_id_o, br_valid_o, count_o); end
    tick();
    n_checks++; if (count_o !== 4'd0 || branch_fifo_empty_o !== 1'b1) begin n_fail++; $display("FAIL nt_retire2 got c=%0d e=%0b exp 0 1", count_o, branch_fifo_empty_o); end
  endtask

  task automatic test_same_thread();
    push(3'd5); push(3'd5);
    resolve(3'd5, 1, 32'h40);
    n_checks++; if (br_valid_o !== 1'b1 || br_true_o !== 1'b1 || br_pc_o !== 32'h40 || count_o !== 4'd2) begin n_fail++; $display("FAIL same_tid_old got v=%0b pc=%0h c=%0d exp 1 40 2", br_valid_o, br_pc_o, count_o); end
    br_ack_i = 1; tick();
    n_checks++; if (br_thread_id_o !== 3'd5 || br_valid_o !== 1'b0 || br_pc_o !== 32'h0 || count_o !== 4'd1) begin n_fail++; $display("FAIL same_tid_young got t=%0d v=%0b pc=%0h c=%0d exp 5 0 0 1", br_thread_id_o, br_valid_o, br_pc_o, count_o); end
    do_reset();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) push(3'(i));
    n_checks++; if (full_o !== 1'b1 || count_o !== 4'd8 || err_o !== 1'b0) begin n_fail++; $display("FAIL fill got f=%0b c=%0d err=%0b exp 1 8 0", full_o, count_o, err_o); end
    push(3'd0);
    n_checks++; if (count_o !== 4'd8 || err_o !== 1'b1 || br_thread_id_o !== 3'd0) begin n_fail++; $display("FAIL overflow got c=%0d err=%0b t=%0d exp 8 1 0", count_o, err_o, br_thread_id_o); end
    resolve(3'd0, 0, 32'h0);
    push(3'd6);
    n_checks++; if (count_o !== 4'd8 || full_o !== 1'b1 || br_thread_id_o !== 3'd1 || br_valid_o !== 1'b0) begin n_fail++; $display("FAIL push_pop_full got c=%0d f=%0b t=%0d v=%0b exp 8 1 1 0", count_o, full_o, br_thread_id_o, br_valid_o); end
    // Drain by resolving oldest-first; the wrapped entry (tid 6 pushed last) must come out last.
    for (int i = 1; i < 8; i++) resolve(3'(i), 0, 32'h0);
    tick();
    n_checks++; if (br_thread_id_o !== 3'd6 || count_o !== 4'd1 || br_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_tail got t=%0d c=%0d v=%0b exp 6 1 0", br_thread_id_o, count_o, br_valid_o); end
    do_reset();
  endtask

  task automatic test_orphan_and_reset();
    push(3'd2);
    resolve(3'd7, 1, 32'hdead);
    n_checks++; if (err_o !== 1'b1 || count_o !== 4'd1 || br_valid_o !== 1'b0 || br_thread_id_o !== 3'd2) begin n_fail++; $display("FAIL orphan got err=%0b c=%0d v=%0b t=%0d exp 1 1 0 2", err_o, count_o, br_valid_o, br_thread_id_o); end
    // Resolving the entry being pushed in the same cycle is an orphan.
    do_reset();
    enq_valid_i = 1; enq_thread_id_i = 3'd4;
    res_valid_i = 1; res_thread_id_i = 3'd4; res_taken_i = 1; res_target_i = 32'h80;
    tick();
    n_checks++; if (err_o !== 1'b1 || br_valid_o !== 1'b0 || count_o !== 4'd1) begin n_fail++; $display("FAIL same_cycle_res got err=%0b v=%0b c=%0d exp 1 0 1", err_o, br_valid_o, count_o); end
    push(3'd1); push(3'd2);
    do_reset();
    n_checks++; if (count_o !== 4'd0 || branch_fifo_empty_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset got c=%0d e=%0b err=%0b exp 0 1 0", count_o, branch_fifo_empty_o, err_o); end
  endtask

  task automatic test_random();
    logic [2:0] etid;
    bit ev, et;
    logic [31:0] epc;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) do_reset();
      enq_valid_i     = ($urandom_range(0, 99) < 45);
      enq_thread_id_i = 3'($urandom_range(0, 3));
      res_valid_i     = ($urandom_range(0, 99) < 40);
      res_thread_id_i = 3'($urandom_range(0, 3));
      res_taken_i     = 1'($urandom_range(0, 1));
      res_target_i    = $urandom;
      br_ack_i        = 1'($urandom_range(0, 1));
      pc_stall_i      = ($urandom_range(0, 99) < 30);
      tick();
      ev   = exp_q.size() > 0 && exp_q[0].res;
      et   = ev && exp_q[0].tk;
      etid = exp_q.size() > 0 ? exp_q[0].tid : 3'd0;
      epc  = et ? exp_q[0].tgt : 32'h0;
      n_checks++; if (count_o !== 4'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, count_o, exp_q.size()); end
      n_checks++; if (branch_fifo_empty_o !== (exp_q.size() == 0) || full_o !== (exp_q.size() == 8)) begin n_fail++; $display("FAIL rnd_flags cyc %0d got e=%0b f=%0b exp size %0d", cyc, branch_fifo_empty_o, full_o, exp_q.size()); end
      n_checks++; if (br_thread_id_o !== etid || br_valid_o !== ev || br_true_o !== et) begin n_fail++; $display("FAIL rnd_head cyc %0d got t=%0d v=%0b tr=%0b exp %0d %0b %0b", cyc, br_thread_id_o, br_valid_o, br_true_o, etid, ev, et); end
      n_checks++; if (br_pc_o !== epc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %0h exp %0h", cyc, br_pc_o, epc); end
      n_checks++; if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %0b exp %0b", cyc, err_o, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_taken_redirect();
    test_not_taken_order();
    test_same_thread();
    test_full();
    test_orphan_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
